// File: rtl/irrigation_pkg.sv
// ----------------------------------------------------------------------------
// Module   : irrigation_pkg
// Brief    : Shared state encoding and level constants for the irrigation
//            scheduler.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package irrigation_pkg;

  localparam int c_lvl_w        = 3;
  localparam int c_low_lvl_def  = 2;
  localparam int c_full_lvl_def = 7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_SPRINKLE = 3'd2,
    ST_DRIP     = 3'd3,
    ST_FAULT    = 3'd4
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/irrigation_scheduler_sched_timer.sv
// ----------------------------------------------------------------------------
// Module   : sched_timer
// Brief    : Saturating state-residency counter with synchronous clear and a
//            greater-or-equal compare against a runtime limit.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sched_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] c_max = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (r_count != c_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign at_limit = (r_count >= limit);

endmodule

`default_nettype wire

// File: rtl/irrigation_scheduler.sv
// ----------------------------------------------------------------------------
// Module   : irrigation_scheduler
// Brief    : Sequences tank fill, sprinkler and dripper valves with minimum run
//            time, refill priority and a latched sensor fault.
//            Optional FILL watchdog: define SCHED_FILL_TIMEOUT_EN.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int LOW_LVL      = c_low_lvl_def,
  parameter int FULL_LVL     = c_full_lvl_def,
  parameter int MIN_RUN      = 16,
  parameter int FILL_TIMEOUT = 1024,
  parameter int CNT_W        = 11
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [c_lvl_w-1:0] level,
  input  logic               soil_dry,
  input  logic               soil_wet,
  output logic               valve_fill,
  output logic               sprinkler_on,
  output logic               dripper_on,
  output logic               alarm,
  output logic [2:0]         state_o
);

  localparam logic [c_lvl_w-1:0] c_low      = c_lvl_w'(LOW_LVL);
  localparam logic [c_lvl_w-1:0] c_full     = c_lvl_w'(FULL_LVL);
  localparam logic [CNT_W-1:0]   c_run_lim  = CNT_W'(MIN_RUN - 1);
  localparam logic [CNT_W-1:0]   c_fill_lim = CNT_W'(FILL_TIMEOUT - 1);

  sched_state_t     r_state;
  sched_state_t     w_next;
  logic             w_at_limit;
  logic             w_clear;
  logic [CNT_W-1:0] w_limit;

  // One timer serves both the minimum-run check and the FILL watchdog.
  assign w_limit = (r_state == ST_FILL) ? c_fill_lim : c_run_lim;
  assign w_clear = (w_next != r_state);

  sched_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (w_clear),
    .limit    (w_limit),
    .at_limit (w_at_limit)
  );

  always_comb begin
    w_next = r_state;
    if (soil_dry && soil_wet && (r_state != ST_FAULT)) begin
      w_next = ST_FAULT;
    end else if (r_state == ST_FAULT) begin
      w_next = enable ? ST_FAULT : ST_IDLE;
    end else if (!enable) begin
      w_next = ST_IDLE;
    end else if ((level <= c_low) && (r_state != ST_FILL)) begin
      w_next = ST_FILL;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (soil_dry)       w_next = ST_SPRINKLE;
          else if (!soil_wet) w_next = ST_DRIP;
          else                w_next = ST_IDLE;
        end
        ST_FILL: begin
          if (level >= c_full) w_next = ST_IDLE;
`ifdef SCHED_FILL_TIMEOUT_EN
          else if (w_at_limit) w_next = ST_FAULT;
`else
          else w_next = ST_FILL;
`endif
        end
        ST_SPRINKLE: begin
          if (w_at_limit) begin
            if (soil_wet)       w_next = ST_IDLE;
            else if (!soil_dry) w_next = ST_DRIP;
          end
        end
        ST_DRIP: begin
          if (w_at_limit) begin
            if (soil_wet)      w_next = ST_IDLE;
            else if (soil_dry) w_next = ST_SPRINKLE;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they track state_o exactly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      valve_fill   <= 1'b0;
      sprinkler_on <= 1'b0;
      dripper_on   <= 1'b0;
      alarm        <= 1'b0;
    end else begin
      r_state      <= w_next;
      valve_fill   <= (w_next == ST_FILL);
      sprinkler_on <= (w_next == ST_SPRINKLE);
      dripper_on   <= (w_next == ST_DRIP);
      alarm        <= (w_next == ST_FAULT);
    end
  end

  assign state_o = r_state;

endmodule

`default_nettype wire

// File: tb/tb_irrigation_scheduler.sv
// ----------------------------------------------------------------------------
// Module   : tb_irrigation_scheduler
// Brief    : Directed and random checks of irrigation_scheduler.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_irrigation_scheduler;

  // Packed view {valve_fill, sprinkler_on, dripper_on, alarm, state_o}
  localparam logic [6:0] c_o_idle = 7'b0000_000;
  localparam logic [6:0] c_o_fill = 7'b1000_001;
  localparam logic [6:0] c_o_spr  = 7'b0100_010;
  localparam logic [6:0] c_o_drip = 7'b0010_011;
  localparam logic [6:0] c_o_flt  = 7'b0001_100;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] level = 3'd5;
  logic       soil_dry = 1'b0;
  logic       soil_wet = 1'b0;
  logic       valve_fill, sprinkler_on, dripper_on, alarm;
  logic [2:0] state_o;

  int n_total = 0;
  int n_bad   = 0;

  irrigation_scheduler #(
    .LOW_LVL      (2),
    .FULL_LVL     (7),
    .MIN_RUN      (16),
    .FILL_TIMEOUT (32),
    .CNT_W        (11)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .level        (level),
    .soil_dry     (soil_dry),
    .soil_wet     (soil_wet),
    .valve_fill   (valve_fill),
    .sprinkler_on (sprinkler_on),
    .dripper_on   (dripper_on),
    .alarm        (alarm),
    .state_o      (state_o)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] outs();
    return {valve_fill, sprinkler_on, dripper_on, alarm, state_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    logic fill_held;
    logic onehot_ok;

    // Reset state
    tick(2);
    chk("reset_state", outs(), c_o_idle);
    reset = 1'b1;

    // Enter SPRINKLE, then async reset mid-cycle
    enable = 1'b1; level = 3'd5; soil_dry = 1'b1; soil_wet = 1'b0;
    tick();
    chk("spr_entry", outs(), c_o_spr);
    tick(3);
    #2 reset = 1'b0;
    #1;
    chk("async_reset", outs(), c_o_idle);
    #1 reset = 1'b1;
    tick();
    chk("spr_after_reset", outs(), c_o_spr);

    // Minimum run: wet arrives early, exit only at cycle 16
    enable = 1'b0;
    tick();
    chk("disable_idle", outs(), c_o_idle);
    enable = 1'b1; soil_dry = 1'b1; soil_wet = 1'b0;
    tick();
    chk("spr_c0", outs(), c_o_spr);
    for (int k = 1; k <= 15; k++) begin
      if (k == 4) begin
        soil_dry = 1'b0;
        soil_wet = 1'b1;
      end
      tick();
      if (k == 4)  chk("spr_c4_hold", outs(), c_o_spr);
      if (k == 15) chk("spr_c15_hold", outs(), c_o_spr);
    end
    tick();
    chk("spr_c16_idle", outs(), c_o_idle);

    // DRIP, then refill preempts before minimum run
    soil_wet = 1'b0; soil_dry = 1'b0; level = 3'd5;
    tick();
    chk("drip_c0", outs(), c_o_drip);
    tick(4);
    chk("drip_c4", outs(), c_o_drip);
    level = 3'd2;
    tick();
    chk("drip_to_fill", outs(), c_o_fill);
    for (int l = 3; l <= 6; l++) begin
      level = 3'(l);
      tick();
      chk($sformatf("fill_lvl%0d", l), outs(), c_o_fill);
    end
    level = 3'd7;
    tick();
    chk("fill_full_exit", outs(), c_o_idle);
    tick();
    chk("drip_resume", outs(), c_o_drip);

    // Sensor fault while filling, latched until enable drops
    level = 3'd1;
    tick();
    chk("fill_again", outs(), c_o_fill);
    soil_dry = 1'b1; soil_wet = 1'b1;
    tick();
    chk("fault_entry", outs(), c_o_flt);
    soil_dry = 1'b0; soil_wet = 1'b0; level = 3'd5;
    tick(3);
    chk("fault_latched", outs(), c_o_flt);
    enable = 1'b0;
    tick();
    chk("fault_clear", outs(), c_o_idle);

    // enable falling in FILL closes the valve on the next edge
    enable = 1'b1; level = 3'd1;
    tick();
    chk("fill_en", outs(), c_o_fill);
    enable = 1'b0;
    tick();
    chk("fill_disable", outs(), c_o_idle);

    // FILL watchdog
    enable = 1'b1; level = 3'd2;
    tick();
    chk("wd_fill_entry", outs(), c_o_fill);
    level = 3'd3;
`ifdef SCHED_FILL_TIMEOUT_EN
    tick(31);
    chk("wd_c31_fill", outs(), c_o_fill);
    tick();
    chk("wd_c32_fault", outs(), c_o_flt);
`else
    fill_held = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      tick();
      if (outs() != c_o_fill) fill_held = 1'b0;
    end
    chk("no_wd_fill_held", fill_held, 1'b1);
`endif
    enable = 1'b0;
    tick();
    chk("wd_exit_idle", outs(), c_o_idle);

    // Random stimulus: actuator exclusivity and legal state encodings
    for (int k = 0; k < 10000; k++) begin
      enable   = ($urandom_range(0, 15) != 0);
      level    = 3'($urandom_range(0, 7));
      soil_dry = ($urandom_range(0, 2) == 0);
      soil_wet = ($urandom_range(0, 2) == 0);
      tick();
      onehot_ok = ((32'(valve_fill) + 32'(sprinkler_on) + 32'(dripper_on)) <= 1);
      chk("rnd_onehot", onehot_ok, 1'b1);
      chk("rnd_state_range", (state_o <= 3'd4), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
